multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the RV64 subset the processor executes: R-type, ld, sd, beq and addi. It replaces single-cycle decode with a Moore/Mealy FSM that steps a shared-ALU, shared-memory datapath through FETCH, DECODE, EXECUTE, MEM and WB. It handshakes with a variable-latency unified memory via mem_ready and traps on illegal opcodes or memory timeout.

Parameters:
TIMEOUT_CYCLES, 16, max cycles a memory access may wait for mem_ready before trapping (≥2)
CNT_W, 32, width of the optional retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
Opcode  input  7  instruction[6:0] from the IR; valid from DECODE onward
mem_ready  input  1  memory completes the current access this cycle
IRWrite  output  1  load the IR
PCWrite  output  1  unconditional PC write
Branch  output  1  conditional PC write; datapath gates with Zero
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
MemtoReg  output  1  writeback select: 1 = MDR, 0 = ALUOut
RegWrite  output  1  register-file write enable
ALUSrcA  output  1  0 = PC, 1 = rs1
ALUSrcB  output  2  00 = rs2, 01 = const 4, 10 = imm, 11 = branch imm
ALUOp  output  2  00 = add, 01 = sub/compare, 10 = funct-decoded
PCSource  output  1  0 = ALU result, 1 = ALUOut (branch target)
trap  output  1  sticky fault flag
trap_cause  output  2  01 = illegal opcode, 10 = memory timeout
state_o  output  4  current state encoding, for debug
instret  output  CNT_W  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (async on reset_n low): state = IDLE. All outputs 0, trap_cause = 00, wait counter = 0, instret = 0. This holds for assertion mid-instruction as well.
- IDLE: all controls 0; moves to FETCH on the next clk edge after reset_n is released.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0.
  - If mem_ready: IRWrite=1 and PCWrite=1 in the same cycle (Mealy), then go to DECODE.
  - Otherwise hold all outputs and stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (pre-computes the branch target). Next state by Opcode:
  - 0110011 -> EXEC
  - 0000011 and 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 0010011 -> ADDI_EX
  - anything else -> TRAP with cause 01
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; go to ALU_WB.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; go to ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0; retire; go to FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM_RD if Opcode = 0000011, otherwise MEM_WR.
- MEM_RD: IorD=1, MemRead=1; wait for mem_ready, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1; retire; go to FETCH.
- MEM_WR: IorD=1, MemWrite=1; wait for mem_ready, then retire and go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSource=1; retire; go to FETCH.
- Memory waits: a wait counter counts cycles in FETCH, MEM_RD and MEM_WR. It clears on mem_ready and on every state change.
  - If mem_ready is still low when the counter equals TIMEOUT_CYCLES-1, go to TRAP with cause 10.
  - mem_ready arriving on that same cycle wins: no trap.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- TRAP: all controls 0, trap=1, trap_cause held. TRAP is left only via reset_n.
- Minimum latency with mem_ready=1:
  - beq: 3 cycles
  - R-type, addi, sd: 4 cycles
  - ld: 5 cycles
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, ADDI_EX=4, ALU_WB=5, MEM_ADDR=6, MEM_RD=7, MEM_WB=8, MEM_WR=9, BRANCH=10, TRAP=11.
- Unused encodings 12-15 go to TRAP with cause 01.

Optional Feature:
Macro: MCFSM_INSTRET_EN.
- Defined: instret increments by 1 on every retire (exit from ALU_WB, MEM_WB or BRANCH, and the completing cycle of MEM_WR). It wraps from 2^CNT_W-1 to 0 and does not count in TRAP.
- Undefined: the counter is not built and instret is tied to 0.

Decomposition:
- Shared package mcfsm_pkg holds:
  - opcode constants (OP_RTYPE, OP_LD, OP_SD, OP_BEQ, OP_ADDI)
  - the state enum/localparams
  - ALUOp and ALUSrcB encodings
  - trap_cause codes
- One sub-module, mcfsm_wait_timer (counter plus timeout compare), is natural; the output decode stays inline.

Test Plan:
1. reset_n low mid-MEM_RD, then released -> all outputs 0, state_o=0; FETCH on the next edge; instret=0.
2. R-type (0110011) with mem_ready=1 -> states 1,2,3,5; RegWrite=1 only in cycle 4; instret +1.
3. ld with mem_ready delayed 3 cycles in MEM_RD -> MEM_RD held 4 cycles with IorD=1, MemRead=1; MEM_WB asserts MemtoReg=1, RegWrite=1.
4. beq -> 3 cycles; Branch=1, ALUOp=01, PCSource=1 in BRANCH; PCWrite asserted only in FETCH.
5. Opcode 1111111 at DECODE -> TRAP, trap=1, trap_cause=01; stays in TRAP for 100 cycles until reset.
6. mem_ready held low in FETCH with TIMEOUT_CYCLES=16 -> trap_cause=10 after 16 FETCH cycles. Repeat with mem_ready rising on cycle 16 -> DECODE, no trap.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle control FSM: opcodes, state encoding,
// ALU control encodings, trap causes and the control-word struct.
package mcfsm_pkg;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_SD    = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_ADDI  = 7'b0010011;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC     = 4'd3,
      S_ADDI_EX  = 4'd4,
      S_ALU_WB   = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_MEM_WB   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_BRANCH   = 4'd10,
      S_TRAP     = 4'd11
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_e;

   typedef enum logic [1:0] {
      SRCB_RS2  = 2'b00,
      SRCB_FOUR = 2'b01,
      SRCB_IMM  = 2'b10,
      SRCB_BIMM = 2'b11
   } alu_src_b_e;

   typedef enum logic [1:0] {
      TC_NONE    = 2'b00,
      TC_ILLEGAL = 2'b01,
      TC_TIMEOUT = 2'b10
   } trap_cause_e;

   typedef struct packed {
      logic       ir_write;
      logic       pc_write;
      logic       branch;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      alu_src_b_e alu_src_b;
      alu_op_e    alu_op;
      logic       pc_source;
   } ctrl_t;

   // States in which the FSM is stalled on the memory handshake.
   function automatic logic is_wait_state(input state_e s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle sequencer (master) and the shared
// datapath / unified memory (slave).
interface multicycle_control_fsm_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       Opcode;
   logic             mem_ready;
   logic             IRWrite;
   logic             PCWrite;
   logic             Branch;
   logic             IorD;
   logic             MemRead;
   logic             MemWrite;
   logic             MemtoReg;
   logic             RegWrite;
   logic             ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ALUOp;
   logic             PCSource;
   logic             trap;
   logic [1:0]       trap_cause;
   logic [3:0]       state_o;
   logic [CNT_W-1:0] instret;

   modport master (
      input  Opcode, mem_ready,
      output IRWrite, PCWrite, Branch, IorD, MemRead, MemWrite, MemtoReg,
             RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, trap, trap_cause,
             state_o, instret
   );

   modport slave (
      output Opcode, mem_ready,
      input  IRWrite, PCWrite, Branch, IorD, MemRead, MemWrite, MemtoReg,
             RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, trap, trap_cause,
             state_o, instret
   );
endinterface

// File: rtl/multicycle_control_fsm_wait_timer.sv
// Memory-wait counter: counts stalled cycles and flags a timeout on the last
// allowed cycle when mem_ready is still low.
module mcfsm_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic count_en,
   input  logic mem_ready,
   input  logic clear,
   output logic timeout
);
   localparam int unsigned W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] CNT_MAX = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      if (!count_en || mem_ready || clear) cnt_d = '0;
      else                                 cnt_d = cnt_q + W'(1);
   end

   // A completing access on the last allowed cycle wins over the timeout.
   assign timeout = count_en && !mem_ready && (cnt_q == CNT_MAX);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control FSM for the RV64 subset (R-type, ld, sd, beq, addi).
// Optional retired-instruction counter enabled by `define MCFSM_INSTRET_EN.
module multicycle_control_fsm
   import mcfsm_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 32
) (
   input logic                     clk,
   input logic                     reset_n,
   multicycle_control_fsm_if.master bus
);
   state_e      state_q, state_d;
   trap_cause_e cause_q, cause_d;
   ctrl_t       ctrl;
   logic        wait_en;
   logic        timeout;

   assign wait_en = is_wait_state(state_q);

   mcfsm_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .count_en  (wait_en),
      .mem_ready (bus.mem_ready),
      .clear     (state_d != state_q),
      .timeout   (timeout)
   );

   // NOTE: every always_comb output gets a default first, so no path leaves a
   // variable unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      unique case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH: begin
            if (bus.mem_ready)  state_d = S_DECODE;
            else if (timeout) begin
               state_d = S_TRAP;
               cause_d = TC_TIMEOUT;
            end
         end
         S_DECODE: begin
            if      (bus.Opcode == OP_RTYPE) state_d = S_EXEC;
            else if (bus.Opcode == OP_LD ||
                     bus.Opcode == OP_SD)    state_d = S_MEM_ADDR;
            else if (bus.Opcode == OP_BEQ)   state_d = S_BRANCH;
            else if (bus.Opcode == OP_ADDI)  state_d = S_ADDI_EX;
            else begin
               state_d = S_TRAP;
               cause_d = TC_ILLEGAL;
            end
         end
         S_EXEC, S_ADDI_EX: state_d = S_ALU_WB;
         S_ALU_WB, S_MEM_WB, S_BRANCH: state_d = S_FETCH;
         S_MEM_ADDR: state_d = (bus.Opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD, S_MEM_WR: begin
            if (bus.mem_ready) state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
            else if (timeout) begin
               state_d = S_TRAP;
               cause_d = TC_TIMEOUT;
            end
         end
         S_TRAP: state_d = S_TRAP;
         default: begin
            state_d = S_TRAP;
            cause_d = TC_ILLEGAL;
         end
      endcase
   end

   // Output decode: Moore from state, except the Mealy IR/PC write in FETCH.
   always_comb begin
      ctrl = '0;
      unique case (state_q)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ir_write  = bus.mem_ready;
            ctrl.pc_write  = bus.mem_ready;
         end
         S_DECODE: ctrl.alu_src_b = SRCB_BIMM;
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RS2;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_ADDI_EX, S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_ALU_WB: ctrl.reg_write = 1'b1;
         S_MEM_RD: begin
            ctrl.i_or_d   = 1'b1;
            ctrl.mem_read = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.i_or_d    = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RS2;
            ctrl.alu_op    = ALU_SUB;
            ctrl.branch    = 1'b1;
            ctrl.pc_source = 1'b1;
         end
         default: ;
      endcase
   end

   // NOTE: async active-low reset covers every flop, so an abort mid-instruction
   // lands cleanly in IDLE with a cleared trap cause.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cause_q <= TC_NONE;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

   assign bus.IRWrite    = ctrl.ir_write;
   assign bus.PCWrite    = ctrl.pc_write;
   assign bus.Branch     = ctrl.branch;
   assign bus.IorD       = ctrl.i_or_d;
   assign bus.MemRead    = ctrl.mem_read;
   assign bus.MemWrite   = ctrl.mem_write;
   assign bus.MemtoReg   = ctrl.mem_to_reg;
   assign bus.RegWrite   = ctrl.reg_write;
   assign bus.ALUSrcA    = ctrl.alu_src_a;
   assign bus.ALUSrcB    = ctrl.alu_src_b;
   assign bus.ALUOp      = ctrl.alu_op;
   assign bus.PCSource   = ctrl.pc_source;
   assign bus.trap       = (state_q == S_TRAP);
   assign bus.trap_cause = cause_q;
   assign bus.state_o    = state_q;

`ifdef MCFSM_INSTRET_EN
   logic             retire;
   logic [CNT_W-1:0] instret_q, instret_d;

   assign retire = (state_q == S_ALU_WB) || (state_q == S_MEM_WB) ||
                   (state_q == S_BRANCH) || (state_q == S_MEM_WR && bus.mem_ready);

   always_comb instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) instret_q <= '0;
      else          instret_q <= instret_d;
   end

   assign bus.instret = instret_q;
`else
   assign bus.instret = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed scenarios followed by
// randomized instruction streams checked against a per-instruction cycle model.
module tb_multicycle_control_fsm;
   localparam int T = 16;

   localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3, S_ADDI_EX = 4,
                  S_ALU_WB = 5, S_MEM_ADDR = 6, S_MEM_RD = 7, S_MEM_WB = 8,
                  S_MEM_WR = 9, S_BRANCH = 10, S_TRAP = 11;

   localparam logic [6:0] RTYPE = 7'b0110011, LD = 7'b0000011, SD = 7'b0100011,
                          BEQ = 7'b1100011, ADDI = 7'b0010011;

`ifdef MCFSM_INSTRET_EN
   localparam bit INSTRET_EN = 1'b1;
`else
   localparam bit INSTRET_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   multicycle_control_fsm_if #(.CNT_W(32)) bus ();

   multicycle_control_fsm #(.TIMEOUT_CYCLES(T), .CNT_W(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [1:0]  exp_cause;
   logic [31:0] exp_instret;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected {controls, trap, trap_cause} straight from the per-state table.
   function automatic logic [16:0] exp_ctrl(input int st, input bit rdy, input logic [1:0] cause);
      logic irw, pcw, br, iord, mr, mw, m2r, rw, sa, pcs, trp;
      logic [1:0] sb, op;
      {irw, pcw, br, iord, mr, mw, m2r, rw, sa, pcs, trp} = '0;
      sb = 2'b00;
      op = 2'b00;
      case (st)
         S_FETCH:    begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
         S_DECODE:   sb = 2'b11;
         S_EXEC:     begin sa = 1; sb = 2'b00; op = 2'b10; end
         S_ADDI_EX:  begin sa = 1; sb = 2'b10; end
         S_ALU_WB:   rw = 1;
         S_MEM_ADDR: begin sa = 1; sb = 2'b10; end
         S_MEM_RD:   begin iord = 1; mr = 1; end
         S_MEM_WB:   begin rw = 1; m2r = 1; end
         S_MEM_WR:   begin iord = 1; mw = 1; end
         S_BRANCH:   begin sa = 1; op = 2'b01; br = 1; pcs = 1; end
         S_TRAP:     trp = 1;
         default:    ;
      endcase
      return {irw, pcw, br, iord, mr, mw, m2r, rw, sa, sb, op, pcs, trp,
              (st == S_TRAP) ? cause : 2'b00};
   endfunction

   function automatic logic [16:0] got_ctrl();
      return {bus.IRWrite, bus.PCWrite, bus.Branch, bus.IorD, bus.MemRead, bus.MemWrite,
              bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
              bus.PCSource, bus.trap, bus.trap_cause};
   endfunction

   function automatic bit is_legal(input logic [6:0] op);
      return op == RTYPE || op == LD || op == SD || op == BEQ || op == ADDI;
   endfunction

   // One clock: apply inputs just after the edge, compare at the falling edge.
   task automatic cycle(input int st, input bit rdy, input logic [6:0] opc);
      bus.mem_ready = rdy;
      bus.Opcode    = opc;
      @(negedge clk);
      check($sformatf("state(exp %0d)", st), 64'(bus.state_o), 64'(st));
      check($sformatf("ctrl(state %0d)", st), 64'(got_ctrl()), 64'(exp_ctrl(st, rdy, exp_cause)));
      @(posedge clk);
      #1;
   endtask

   // A memory wait of d stalled cycles; beyond T-1 stalls the access times out.
   task automatic wait_phase(input int st, input int d, input logic [6:0] opc, output bit timed_out);
      int n;
      n = (d > T - 1) ? T : d + 1;
      for (int i = 0; i < n; i++)
         cycle(st, (i == d), (st == S_FETCH) ? 7'($urandom) : opc);
      timed_out = (d > T - 1);
      if (timed_out) exp_cause = 2'b10;
   endtask

   task automatic run_instr(input logic [6:0] op, input int d_f, input int d_m, output bit trapped);
      bit to;
      trapped = 1'b0;
      wait_phase(S_FETCH, d_f, op, to);
      if (to) begin trapped = 1'b1; return; end
      cycle(S_DECODE, 1'($urandom), op);
      case (op)
         RTYPE, ADDI: begin
            cycle((op == RTYPE) ? S_EXEC : S_ADDI_EX, 1'($urandom), op);
            cycle(S_ALU_WB, 1'($urandom), op);
         end
         BEQ: cycle(S_BRANCH, 1'($urandom), op);
         LD, SD: begin
            cycle(S_MEM_ADDR, 1'($urandom), op);
            wait_phase((op == LD) ? S_MEM_RD : S_MEM_WR, d_m, op, to);
            if (to) begin trapped = 1'b1; return; end
            if (op == LD) cycle(S_MEM_WB, 1'($urandom), op);
         end
         default: begin
            exp_cause = 2'b01;
            trapped   = 1'b1;
            return;
         end
      endcase
      exp_instret++;
      check("instret", 64'(bus.instret), INSTRET_EN ? 64'(exp_instret) : 64'd0);
   endtask

   task automatic trap_hold(input int n);
      for (int i = 0; i < n; i++) cycle(S_TRAP, 1'($urandom), 7'($urandom));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      exp_cause   = 2'b00;
      exp_instret = '0;
      check("reset state", 64'(bus.state_o), 64'(S_IDLE));
      check("reset ctrl", 64'(got_ctrl()), 64'd0);
      check("reset instret", 64'(bus.instret), 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cycle(S_IDLE, 1'($urandom), 7'($urandom));
   endtask

   function automatic int rand_delay();
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 14) return r % 4;
      if (r < 17) return T - 1;
      return T;
   endfunction

   initial begin
      bit         trapped;
      logic [6:0] op;
      logic [6:0] ops[5];
      ops = '{RTYPE, LD, SD, BEQ, ADDI};
      reset_n       = 1'b0;
      bus.mem_ready = 1'b0;
      bus.Opcode    = '0;
      exp_cause     = 2'b00;
      exp_instret   = '0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Reset asserted mid-MEM_RD.
      cycle(S_FETCH, 1'b1, 7'($urandom));
      cycle(S_DECODE, 1'b0, LD);
      cycle(S_MEM_ADDR, 1'b0, LD);
      cycle(S_MEM_RD, 1'b0, LD);
      cycle(S_MEM_RD, 1'b0, LD);
      do_reset();

      run_instr(RTYPE, 0, 0, trapped);
      run_instr(LD, 0, 3, trapped);
      run_instr(BEQ, 0, 0, trapped);
      run_instr(SD, 1, 2, trapped);
      run_instr(ADDI, 2, 0, trapped);

      run_instr(7'b1111111, 0, 0, trapped);
      check("illegal trapped", 64'(trapped), 64'd1);
      trap_hold(100);
      do_reset();

      run_instr(ADDI, T, 0, trapped);
      check("fetch timeout trapped", 64'(trapped), 64'd1);
      trap_hold(3);
      do_reset();
      run_instr(ADDI, T - 1, 0, trapped);
      check("fetch last-cycle ready", 64'(trapped), 64'd0);

      for (int k = 0; k < 150; k++) begin
         int sel;
         sel = int'($urandom_range(0, 5));
         if (sel < 5) op = ops[sel];
         else begin
            op = 7'($urandom);
            while (is_legal(op)) op = 7'($urandom);
         end
         run_instr(op, rand_delay(), rand_delay(), trapped);
         if (trapped) begin
            trap_hold(int'($urandom_range(1, 6)));
            do_reset();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
